// File: rtl/gray_pkg.sv
// Shared helpers for the Gray step counter: Gray/binary conversion and width limits.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 16;
  localparam logic [MAX_WIDTH-1:0] GRAY_MAX = {MAX_WIDTH{1'b1}};

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronises a slow level input into the clk domain and flags each rising edge
// with a single-cycle pulse.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to ones so an input already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/gray_step_counter.sv
// Up/down Gray-code counter stepped by rising edges of a slow divided clock that is
// sampled as data on the board clock.
module gray_step_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CountMax = GRAY_MAX[WIDTH-1:0];

  logic                 step;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [WIDTH-1:0]     gray_q, gray_d;
  logic                 wrap_q, wrap_d;
  logic [MAX_WIDTH-1:0] gray_full;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk (clk),
    .rst (rst),
    .d   (tick_in),
    .rise(step)
  );

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    // Load wins over a coincident step; that step is discarded.
    if (load) begin
      bin_d = load_val;
    end else if (step && en) begin
      if (up_dn) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = (bin_q == CountMax);
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = (bin_q == '0);
      end
    end
    gray_full = bin2gray(MAX_WIDTH'(bin_d));
    gray_d    = gray_full[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_step_counter.sv
// Directed scoreboard bench for gray_step_counter (WIDTH=4, SYNC_STAGES=2).
module tb_gray_step_counter;

  typedef struct packed {
    logic [3:0] gray;
    logic [3:0] bin;
    logic [7:0] wraps;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       en = 1'b1;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       wrap;

  int         checks = 0;
  int         errors = 0;
  int         wrap_cnt = 0;
  int         wrap_base = 0;
  logic [3:0] m_bin = '0;
  logic [3:0] prev_gray;
  exp_t       sb[$];

  logic [3:0] up_seq [16];

  gray_step_counter #(
    .WIDTH      (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .gray_out(gray_out),
    .bin_out (bin_out),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap) wrap_cnt++;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] wraps);
    exp_t e;
    e.gray = b2g(m_bin);
    e.bin  = m_bin;
    e.wraps = wraps;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gray"}, 32'(gray_out), 32'(e.gray));
      chk({tag, "_bin"}, 32'(bin_out), 32'(e.bin));
      chk({tag, "_wrap"}, 32'(wrap_cnt - wrap_base), 32'(e.wraps));
    end
  endtask

  task automatic pulse();
    wrap_base = wrap_cnt;
    @(negedge clk) tick_in = 1'b1;
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    m_bin = '0;
  endtask

  initial begin
    up_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset state
    do_reset();
    chk("rst_gray", 32'(gray_out), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    // 16 up steps with the expected Gray table and single-bit transitions
    for (int i = 1; i <= 16; i++) begin
      prev_gray = gray_out;
      m_bin = m_bin + 4'd1;
      push_exp((i == 16) ? 8'd1 : 8'd0);
      pulse();
      chk($sformatf("up%0d_table", i), 32'(gray_out), 32'(up_seq[i % 16]));
      chk($sformatf("up%0d_hamming", i), 32'($countones(gray_out ^ prev_gray)), 32'd1);
      pop_chk($sformatf("up%0d", i));
    end

    // Down from zero wraps to max, then plain decrement
    do_reset();
    up_dn = 1'b0;
    m_bin = 4'd15;
    push_exp(8'd1);
    pulse();
    pop_chk("dn1");
    chk("dn1_gray_lit", 32'(gray_out), 32'b1000);
    m_bin = 4'd14;
    push_exp(8'd0);
    pulse();
    pop_chk("dn2");
    chk("dn2_gray_lit", 32'(gray_out), 32'b1001);
    up_dn = 1'b1;

    // Latency and long-held tick_in gives exactly one step
    do_reset();
    wrap_base = wrap_cnt;
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) chk("lat_e1", 32'(bin_out), 32'd0);
    @(negedge clk) chk("lat_e2", 32'(bin_out), 32'd0);
    @(negedge clk) chk("lat_e3", 32'(bin_out), 32'd1);
    repeat (100) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    m_bin = 4'd1;
    push_exp(8'd0);
    pop_chk("held");

    // Load coincident with a step: load wins, step is lost
    do_reset();
    wrap_base = wrap_cnt;
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk) begin
      load = 1'b1;
      load_val = 4'b0101;
    end
    @(negedge clk) load = 1'b0;
    m_bin = 4'b0101;
    push_exp(8'd0);
    pop_chk("load");
    chk("load_gray_lit", 32'(gray_out), 32'b0111);
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("load_step_dropped", 32'(bin_out), 32'd5);
    m_bin = 4'b0110;
    push_exp(8'd0);
    pulse();
    pop_chk("after_load");
    chk("after_load_gray_lit", 32'(gray_out), 32'b0101);

    // Steps during en=0 are lost, not replayed
    en = 1'b0;
    wrap_base = wrap_cnt;
    repeat (3) pulse();
    push_exp(8'd0);
    pop_chk("en_off");
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("en_no_replay", 32'(bin_out), 32'(m_bin));
    m_bin = m_bin + 4'd1;
    push_exp(8'd0);
    pulse();
    pop_chk("en_on");

    // tick_in high across reset release yields no step until a fresh edge
    tick_in = 1'b1;
    do_reset();
    wrap_base = wrap_cnt;
    repeat (6) @(negedge clk);
    push_exp(8'd0);
    pop_chk("tick_hi_rst");
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    m_bin = 4'd1;
    push_exp(8'd0);
    pulse();
    pop_chk("tick_hi_rst_fresh");

    // Reset mid-count at bin 9
    @(negedge clk) begin
      load = 1'b1;
      load_val = 4'd8;
    end
    @(negedge clk) load = 1'b0;
    m_bin = 4'd9;
    push_exp(8'd0);
    pulse();
    pop_chk("pre_rst9");
    @(negedge clk) rst = 1'b0;
    @(negedge clk) begin
      chk("midrst_bin", 32'(bin_out), 32'd0);
      chk("midrst_gray", 32'(gray_out), 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_step_counter.md
Name: gray_step_counter

Overview:
- Consumes the slow divided-clock output of the clock divider stage and advances a Gray-code count by one on each rising edge of it.
- Runs entirely on the board clock. The divided clock is treated as a data input: synchronised, then edge-detected. It is never used as a clock.
- Drives the LED/display stage with the Gray value, its binary equivalent and a wrap pulse.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- SYNC_STAGES, 2, synchroniser flops on tick_in (2..3).

Ports:
- clk  input  1  board clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- tick_in  input  1  divided clock from the divider stage; each rising edge requests one step.
- en  input  1  step enable; when 0, detected steps are discarded.
- up_dn  input  1  1 = count up, 0 = count down; sampled on the step cycle.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  registered Gray count.
- bin_out  output  WIDTH  registered binary equivalent of gray_out.
- wrap  output  1  one-cycle pulse when a step crosses the max/0 boundary.

Behaviour:
- Reset (rst==0 at a clk edge):
  - bin_out = 0, gray_out = 0, wrap = 0.
  - All synchroniser flops and the edge-history flop are set to 1. A tick_in held high across reset release therefore produces no step.
- Sync/edge detect:
  - tick_in passes through SYNC_STAGES flops.
  - step = sync_last & ~hist, where hist is sync_last delayed one cycle.
  - step is high for exactly one clk cycle per tick_in rising edge, however long tick_in stays high.
- Latency (SYNC_STAGES=2): tick_in rises before edge E1. step is high in the cycle after E2. gray_out/bin_out take their new value at E3. In general the update lands SYNC_STAGES+1 edges after tick_in rises.
- Counter priority per edge: rst low > load > (step & en) > hold.
  - load: bin_out <= load_val, gray_out <= bin2gray(load_val), wrap <= 0. A step on the same cycle is dropped, not deferred.
  - step & en & up_dn: bin <= bin+1, modulo 2^WIDTH.
  - step & en & ~up_dn: bin <= bin-1, modulo 2^WIDTH.
- Gray/binary consistency:
  - gray_out <= bin_next ^ (bin_next >> 1), registered in the same edge as bin_out. The two outputs are always consistent.
  - Consecutive gray_out values from stepping differ in exactly one bit, including across the wrap.
- wrap:
  - Goes to 1 for one cycle when a step moves up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1.
  - 0 otherwise, including on load.
- en low: the edge detector keeps running, so a step occurring while en=0 is lost. Raising en later does not replay it.
- up_dn change between steps: takes effect on the next step. There is no glitch on the outputs.
- Reset mid-operation: takes effect at the next edge regardless of step or load. Pending edge history is cleared to the all-ones state.

Decomposition:
- Package gray_pkg:
  - function bin2gray(WIDTH)
  - function gray2bin (for bench use)
  - localparam GRAY_MAX = {WIDTH{1'b1}}
- One sub-module, edge_sync:
  - ports clk, rst, d, rise
  - parameterised by SYNC_STAGES
  - reset-to-ones behaviour as above
- Counter, wrap logic and output registers live in gray_step_counter.

Test Plan:
- Reset then 16 tick_in pulses, en=1, up_dn=1, WIDTH=4 -> gray_out sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap=1 for one cycle on the 1000->0000 step only. Every transition has Hamming distance 1.
- From reset, up_dn=0, one pulse -> bin_out=15, gray_out=1000, wrap pulse. Second pulse -> bin_out=14, gray_out=1001, no wrap.
- tick_in held high 100 cycles -> exactly one step. Update lands on the 3rd clk edge after the rise.
- load=1, load_val=0101 on the same cycle as a step -> bin_out=0101, gray_out=0111, wrap=0, step dropped. Next pulse -> bin_out=0110, gray_out=0101.
- en=0 during 3 pulses -> outputs unchanged. en=1 then one pulse -> count advances by exactly 1.
- tick_in=1 while rst=0, then release rst -> no step and outputs stay 0 until tick_in falls and rises again. rst asserted mid-count at bin_out=9 -> 0 at the next edge.
